fpu_result_unloader: RTL and testbench



---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_result_unloader.sv | 73 +++++++
 tb/tb_fpu_result_unloader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: default result/flag widths, flag bit positions and the
// result unloader state encoding.
package fpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 5;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned FRAME_BYTES = DATA_W / 8 + 1;

  typedef enum logic {
    UL_IDLE,
    UL_SEND
  } ul_state_e;

endpackage

// File: rtl/fpu_result_unloader.sv
// Captures one FPU result plus its exception flags and drains them as a
// byte frame (data LSB first, then a zero-padded flag byte) over valid/ready.
module fpu_result_unloader #(
  parameter int unsigned DATA_W = fpu_pkg::DATA_W,
  parameter int unsigned FLAG_W = fpu_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] res_data,
  input  logic [FLAG_W-1:0] res_flags,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  import fpu_pkg::*;

  localparam int unsigned NBYTES = DATA_W / 8 + 1;
  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W / 8);

  ul_state_e state_q, state_d;
  logic [NBYTES-1:0][7:0] hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= UL_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    unique case (state_q)
      UL_IDLE: begin
        if (res_valid) begin
          // Flag byte sits above the data so one index walks the whole frame.
          hold_d  = {8'(res_flags), res_data};
          idx_d   = '0;
          state_d = UL_SEND;
        end
      end
      UL_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = UL_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = UL_IDLE;
    endcase
  end

  assign res_ready = (state_q == UL_IDLE);
  assign out_valid = (state_q == UL_SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_byte  = out_valid ? hold_q[idx_q] : 8'h00;

endmodule

// File: tb/tb_fpu_result_unloader.sv
// Scoreboard bench for fpu_result_unloader: directed scenarios plus random
// frames, each captured result expanded into its expected byte frame.
module tb_fpu_result_unloader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] res_data = '0;
  logic [4:0]  res_flags = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;

  fpu_result_unloader dut (
    .clk       (clk),
    .rstn      (rstn),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int cap_cnt = 0;
  int last_cap_cyc = 0;
  int last_hs_cyc = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at negedge: the head of exp_q is the byte that must be on
  // the port; a frame is five bytes and the unloader is free iff none remain.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      bit in_frame;
      cyc++;
      in_frame = (exp_q.size() != 0);
      check("res_ready", 32'(res_ready), 32'(!in_frame));
      check("busy", 32'(busy), 32'(in_frame));
      check("out_valid", 32'(out_valid), 32'(in_frame));
      if (in_frame) begin
        check("out_byte", 32'(out_byte), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) last_hs_cyc = cyc;
        end
      end else begin
        check("idle_byte", 32'(out_byte), 32'h0);
        check("idle_last", 32'(out_last), 32'h0);
        if (res_valid) begin
          for (int i = 0; i < 4; i++) exp_q.push_back(res_data[8*i +: 8]);
          exp_q.push_back({3'b000, res_flags});
          cap_cnt++;
          last_cap_cyc = cyc;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cap(input int target);
    int n = 0;
    while (cap_cnt < target && n < 200) begin
      step();
      n++;
    end
    if (cap_cnt < target) check("capture_wait", 32'(cap_cnt), 32'(target));
  endtask

  task automatic wait_left(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() > left) check("drain_wait", 32'(exp_q.size()), 32'(left));
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] f);
    int t;
    t = cap_cnt + 1;
    res_data  = d;
    res_flags = f;
    res_valid = 1'b1;
    wait_cap(t);
    res_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_res_ready", 32'(res_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_out_byte", 32'(out_byte), 32'h0);
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Basic frame
    out_ready = 1'b1;
    send(32'h3F80_0000, 5'b00001);
    wait_left(0);
    step();

    // Backpressure at byte 2
    send(32'hDEAD_BEEF, 5'b00000);
    wait_left(3);
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_left(0);
    step();

    // Result offered during SEND must wait for the frame to finish
    begin
      int c;
      c = cap_cnt;
      res_data  = 32'h1234_5678;
      res_flags = 5'b00000;
      res_valid = 1'b1;
      wait_cap(c + 1);
      res_data  = 32'hFFFF_FFFF;
      res_flags = 5'b10101;
      wait_cap(c + 2);
      res_valid = 1'b0;
      wait_left(0);
      step();
    end

    // Asynchronous reset mid-frame
    send(32'hCAFE_F00D, 5'b00110);
    wait_left(3);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_res_ready", 32'(res_ready), 32'h1);
    check("midrst_out_byte", 32'(out_byte), 32'h0);
    repeat (2) step();
    rstn = 1'b1;
    step();
    send(32'h0000_0001, 5'b00000);
    wait_left(0);
    step();

    // Back-to-back with res_valid held
    begin
      int c;
      int t0;
      c = cap_cnt;
      res_data  = 32'hA5A5_0F0F;
      res_flags = 5'b01000;
      res_valid = 1'b1;
      wait_cap(c + 1);
      t0 = last_cap_cyc;
      res_data  = 32'h5A5A_F0F0;
      res_flags = 5'b00010;
      wait_cap(c + 2);
      res_valid = 1'b0;
      check("b2b_capture_gap", 32'(last_cap_cyc - t0), 32'd6);
      wait_left(0);
      check("b2b_span", 32'(last_hs_cyc - t0), 32'd11);
      step();
    end

    // All flags set
    send(32'h7F80_0000, 5'b11111);
    wait_left(0);
    step();

    // Random frames under random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send($urandom, 5'($urandom_range(0, 31)));
    end
    wait_left(0);
    rnd_ready = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
